// File: rtl/ef_stim_driver_pkg.sv
// ef_pkg: shared states, timing and tap constants for the stimulus driver.
package ef_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;
    localparam int DRAIN_CYCLES = 4;
    localparam logic [15:0] DEFAULT_SEED = 16'h0001;
    // Feedback taps at bits 15,13,12,10 for both the LFSR and the MISR.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] MISR_TAPS = 16'hB400;
endpackage

// File: rtl/ef_stim_driver_if.sv
// ef_stim_driver_if: control, stimulus and response signals of the driver.
interface ef_stim_driver_if;
    logic start;
    logic [7:0] seq_len;
    logic [15:0] seed;
    logic cfg_mode;
    logic mode;
    logic e;
    logic f;
    logic g;
    logic h;
    logic busy;
    logic done;
    logic [15:0] signature;
    modport master (output start, seq_len, seed, cfg_mode, g, h,
                    input mode, e, f, busy, done, signature);
    modport slave (input start, seq_len, seed, cfg_mode, g, h,
                   output mode, e, f, busy, done, signature);
endinterface

// File: rtl/ef_stim_driver_lfsr16.sv
// ef_lfsr16: 16-bit shift-with-feedback register, usable as LFSR or MISR.
module ef_lfsr16 import ef_pkg::*; #(
    parameter logic [15:0] TAPS = LFSR_TAPS,
    parameter logic [15:0] INIT = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic [1:0]  xin,
    output logic [15:0] q
);
    logic [15:0] nxt;
    assign nxt = {q[14:0], ^(q & TAPS)} ^ {14'b0, xin};
    always_ff @(posedge clk) begin
        if (rst) q <= INIT;
        else if (load) q <= load_val;
        else if (en) q <= nxt;
    end
endmodule

// File: rtl/ef_stim_driver.sv
// ef_stim_driver: drives an LFSR stimulus for seq_len cycles, drains, and
// compresses the downstream response into a MISR signature.
module ef_stim_driver import ef_pkg::*; (
    input logic clk,
    input logic rst,
    ef_stim_driver_if.slave bus
);
    state_t state;
    logic [7:0] cnt;
    logic [1:0] dcnt;
    logic [15:0] lfsr;
    logic accept;
    assign accept = state == IDLE && bus.start;
    ef_lfsr16 #(.TAPS(LFSR_TAPS), .INIT(DEFAULT_SEED)) u_lfsr (
        .clk(clk), .rst(rst), .en(state == DRIVE), .load(accept),
        .load_val(bus.seed == 16'h0 ? DEFAULT_SEED : bus.seed),
        .xin(2'b00), .q(lfsr)
    );
    // The MISR keeps sampling through DRAIN to catch the downstream latency.
    ef_lfsr16 #(.TAPS(MISR_TAPS), .INIT(16'h0)) u_misr (
        .clk(clk), .rst(rst), .en(state == DRIVE || state == DRAIN), .load(accept),
        .load_val(16'h0), .xin({bus.h, bus.g}), .q(bus.signature)
    );
    assign bus.e = state == DRIVE && lfsr[0];
    assign bus.f = state == DRIVE && lfsr[1];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= 8'd0;
            dcnt <= 2'd0;
            bus.mode <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state <= bus.seq_len == 8'd0 ? DRAIN : DRIVE;
                    cnt <= bus.seq_len;
                    dcnt <= 2'd0;
                    bus.mode <= bus.cfg_mode;
                    bus.busy <= 1'b1;
                end
                DRIVE: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) state <= DRAIN;
                end
                DRAIN: begin
                    dcnt <= dcnt + 2'd1;
                    if (dcnt == 2'(DRAIN_CYCLES - 1)) begin
                        state <= DONE;
                        bus.done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ef_stim_driver.sv
// tb_ef_stim_driver: phase-count reference model checked every cycle, plus
// directed runs with hand-computed expectations and a randomized soak.
module tb_ef_stim_driver;
    logic clk = 1'b0;
    logic rst;
    ef_stim_driver_if bus();
    ef_stim_driver dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    bit chk_en = 0;
    bit gh_rand = 0;
    logic g_fix = 0;
    logic h_fix = 0;

    // Model: a run is "active" for L+5 cycles numbered k=1..L+5 after the start edge.
    bit act = 0;
    int k = 0;
    int L = 0;
    logic [15:0] lfsr_m = 16'h0001;
    logic [15:0] sig_m = 16'h0000;
    logic mode_m = 0;

    function automatic logic [15:0] step(input logic [15:0] s, input logic [1:0] x);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {14'b0, x};
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        bus.g = gh_rand ? 1'($urandom) : g_fix;
        bus.h = gh_rand ? 1'($urandom) : h_fix;
    end

    always @(posedge clk) begin
        if (rst) begin
            act = 0; k = 0; mode_m = 0; sig_m = 16'h0; lfsr_m = 16'h0001;
        end else if (act) begin
            if (k <= L + 4) sig_m = step(sig_m, {bus.h, bus.g});
            if (k <= L) lfsr_m = step(lfsr_m, 2'b00);
            if (k == L + 5) act = 0;
            else k++;
        end else if (bus.start) begin
            act = 1; k = 1; L = int'(bus.seq_len);
            lfsr_m = bus.seed == 16'h0 ? 16'h0001 : bus.seed;
            sig_m = 16'h0; mode_m = bus.cfg_mode;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [20:0] got_v, exp_v;
            logic ed;
            ed = act && k <= L;
            got_v = {bus.mode, bus.e, bus.f, bus.busy, bus.done, bus.signature};
            exp_v = {mode_m, ed & lfsr_m[0], ed & lfsr_m[1], act, act && k == L + 5, sig_m};
            checks++;
            if (got_v !== exp_v) begin
                errs++;
                $display("FAIL model t=%0t {mode,e,f,busy,done,sig} got=%h expected=%h", $time, got_v, exp_v);
            end
        end
    end

    task automatic run(input logic [7:0] len, input logic [15:0] sd, input logic m,
                       output int ne, output int nb, output int dat,
                       output logic [15:0] sig, output logic [2:0] eseq);
        @(negedge clk);
        bus.start = 1; bus.seq_len = len; bus.seed = sd; bus.cfg_mode = m;
        @(negedge clk);
        bus.start = 0;
        ne = 0; nb = 0; dat = 0; sig = 16'hDEAD; eseq = 3'b111;
        for (int c = 1; c <= 400; c++) begin
            if (!bus.busy) break;
            ne += int'(bus.e);
            nb += int'(bus.busy);
            if (bus.done) begin dat = c; sig = bus.signature; end
            if (c <= 3) eseq[c-1] = bus.e;
            @(negedge clk);
        end
    endtask

    int ne, nb, dat, dn;
    logic [15:0] sig;
    logic [2:0] eseq;

    initial begin
        rst = 1; bus.start = 0; bus.seq_len = 0; bus.seed = 0; bus.cfg_mode = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_sig", int'(bus.signature), 0);
        rst = 0;

        g_fix = 1; h_fix = 0;
        run(8'd1, 16'h0001, 1'b0, ne, nb, dat, sig, eseq);
        chk("len1_e_cycles", ne, 1);
        chk("len1_busy_cycles", nb, 6);
        chk("len1_done_cycle", dat, 6);
        chk("len1_sig_g1", int'(sig), 16'h001F);
        chk("sig_hold_idle", int'(bus.signature), 16'h001F);
        g_fix = 0;
        run(8'd1, 16'h0001, 1'b1, ne, nb, dat, sig, eseq);
        chk("len1_sig_g0", int'(sig), 16'h0000);
        run(8'd3, 16'h0000, 1'b0, ne, nb, dat, sig, eseq);
        chk("seed0_eseq", int'(eseq), 3'b001);
        chk("seed0_busy", nb, 8);
        run(8'd3, 16'h0001, 1'b0, ne, nb, dat, sig, eseq);
        chk("seed1_eseq", int'(eseq), 3'b001);
        run(8'd0, 16'h1234, 1'b1, ne, nb, dat, sig, eseq);
        chk("len0_e_cycles", ne, 0);
        chk("len0_busy", nb, 5);
        chk("len0_done_cycle", dat, 5);
        gh_rand = 1;
        run(8'd255, 16'hACE1, 1'b0, ne, nb, dat, sig, eseq);
        chk("len255_busy", nb, 260);
        chk("len255_done_cycle", dat, 260);

        // Start re-pulsed mid-DRIVE must be ignored.
        @(negedge clk);
        bus.start = 1; bus.seq_len = 8'd10; bus.seed = 16'h5A5A; bus.cfg_mode = 1;
        dn = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            bus.start = c == 2;
            bus.seq_len = c == 2 ? 8'd2 : 8'd10;
            bus.cfg_mode = c == 2 ? 1'b0 : 1'b1;
            dn += int'(bus.done);
        end
        chk("repulse_done_count", dn, 1);
        chk("repulse_mode_kept", int'(bus.mode), 1);
        run(8'd1, 16'h0001, 1'b0, ne, nb, dat, sig, eseq);
        chk("after_repulse_done", dat, 6);

        // Reset in DRIVE cycle 3 aborts with no done.
        @(negedge clk);
        bus.start = 1; bus.seq_len = 8'd8; bus.seed = 16'hFFFF; bus.cfg_mode = 1;
        @(negedge clk);
        bus.start = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_abort_outputs", int'({bus.mode, bus.e, bus.f, bus.busy, bus.done, bus.signature}), 0);
        dn = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            dn += int'(bus.done);
        end
        chk("rst_abort_no_done", dn, 0);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.start = $urandom_range(0, 5) == 0;
            bus.seq_len = $urandom_range(0, 9) == 0 ? 8'($urandom) : 8'($urandom_range(0, 12));
            bus.seed = $urandom_range(0, 7) == 0 ? 16'h0 : 16'($urandom);
            bus.cfg_mode = 1'($urandom);
            rst = $urandom_range(0, 199) == 0;
        end
        @(negedge clk);
        bus.start = 0; rst = 0;
        repeat (270) @(negedge clk);
        chk("final_idle", int'(bus.busy), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
